// File: rtl/ibus_dbus_arbiter_pkg.sv
// Shared types for the refill-path read arbiter.
// Contents: arbiter state and owner enums, the latched request struct and
// the fixed field widths the struct is built from.
package cpu_defs;

  // Width of the latched address field. A top built with a wider ADDR_W
  // needs this raised to match.
  localparam int PKG_ADDR_W = 32;
  localparam int LEN_W      = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} arb_state_e;

  typedef enum logic {OWNER_INST, OWNER_DATA} arb_owner_e;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]      len;
  } bus_req_t;

endpackage

// File: rtl/ibus_dbus_arbiter_prio_sel.sv
// Winner select between the icache and dcache read requests.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   arb_en     arbitration allowed this cycle (arbiter idle)
//   inst_req   raw icache request, used for starvation tracking
//   inst_elig  icache request that may win this cycle
//   data_req   dcache request
//   pick_inst  icache wins this cycle
//   pick_data  dcache wins this cycle
// Data normally wins. After MAX_WAIT data wins in a row while the icache
// is waiting, a waiting icache request is forced through.
module arb_priority_sel #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic inst_req,
  input  logic inst_elig,
  input  logic data_req,
  output logic pick_inst,
  output logic pick_data
);

  // +2 keeps the counter at least one bit wide even for MAX_WAIT=0.
  localparam int WW = $clog2(MAX_WAIT + 2);

  logic [WW-1:0] wait_cnt;
  logic          force_inst;

  assign force_inst = (wait_cnt == WW'(MAX_WAIT));

  always_comb begin
    pick_data = arb_en & data_req & ~(inst_elig & force_inst);
    pick_inst = arb_en & inst_elig & ~pick_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (!inst_req || pick_inst)
      wait_cnt <= '0;
    else if (pick_data && !force_inst)
      wait_cnt <= wait_cnt + 1'b1;
  end

endmodule

// File: rtl/ibus_dbus_arbiter.sv
// Shares one AR/R read channel between the icache refill path and the
// dcache refill/uncached-read path, one outstanding burst at a time.
// A flushed fetch is drained on the bus without showing beats to the icache.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   inst_req/addr/len/cancel       icache request, len = beats-1, flush
//   inst_grant/rvalid/rlast        icache grant pulse and beat strobes
//   data_req/addr/len              dcache request
//   data_grant/rvalid/rlast        dcache grant pulse and beat strobes
//   rdata                          shared beat data, qualified by rvalid
//   ar_valid/addr/len, ar_ready    bus address channel
//   r_valid/data/last, r_ready     bus data channel
//   proto_err                      sticky: burst length mismatch seen
module ibus_dbus_arbiter
  import cpu_defs::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [3:0]        inst_len,
  input  logic              inst_cancel,
  output logic              inst_grant,
  output logic              inst_rvalid,
  output logic              inst_rlast,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_len,
  output logic              data_grant,
  output logic              data_rvalid,
  output logic              data_rlast,
  output logic [DATA_W-1:0] rdata,
  output logic              ar_valid,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [3:0]        ar_len,
  input  logic              ar_ready,
  input  logic              r_valid,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_last,
  output logic              r_ready,
  output logic              proto_err
);

  arb_state_e state;
  arb_owner_e owner;
  bus_req_t   req_q;
  logic       cancelled;
  logic [3:0] beat_cnt;

  logic live, in_addr, in_data, in_burst;
  logic pick_inst, pick_data;
  logic inst_cxl, beat_fire, beat_err;

  // Outputs are forced quiet while rst is held, not just after it.
  assign live     = ~rst;
  assign in_addr  = live & (state == ADDR);
  assign in_data  = live & (state == DATA);
  assign in_burst = live & ((state == DATA) | (state == DRAIN));

  // Cancel only means something while the icache owns the channel.
  assign inst_cxl  = (owner == OWNER_INST) & inst_cancel;
  assign beat_fire = r_ready & r_valid;
  // Last beat must land exactly on len; any non-last beat at or past len
  // is an overrun.
  assign beat_err  = r_last ? (beat_cnt != req_q.len) : (beat_cnt >= req_q.len);

  arb_priority_sel #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (live & (state == IDLE)),
    .inst_req  (inst_req),
    .inst_elig (inst_req & ~inst_cancel),
    .data_req  (data_req),
    .pick_inst (pick_inst),
    .pick_data (pick_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWNER_INST;
      req_q     <= '0;
      cancelled <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (pick_inst || pick_data) begin
            owner      <= pick_inst ? OWNER_INST : OWNER_DATA;
            req_q.addr <= PKG_ADDR_W'(pick_inst ? inst_addr : data_addr);
            req_q.len  <= pick_inst ? inst_len : data_len;
            cancelled  <= 1'b0;
            state      <= ADDR;
          end
        // The address is never retracted; a cancel here only redirects
        // the burst into DRAIN once the bus has taken it.
        ADDR: begin
          if (inst_cxl) cancelled <= 1'b1;
          if (ar_ready) state <= (cancelled || inst_cxl) ? DRAIN : DATA;
        end
        DATA:
          if (beat_fire && r_last) state <= IDLE;
          else if (inst_cxl)       state <= DRAIN;
        DRAIN:
          if (beat_fire && r_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
    end else if (beat_fire) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (beat_err) proto_err <= 1'b1;
    end
  end

  always_comb begin
    inst_grant  = pick_inst;
    data_grant  = pick_data;
    ar_valid    = in_addr;
    ar_addr     = in_addr ? ADDR_W'(req_q.addr) : '0;
    ar_len      = in_addr ? req_q.len : '0;
    r_ready     = in_burst;
    // A beat landing with the flush is already unwanted by the icache.
    inst_rvalid = in_data & (owner == OWNER_INST) & r_valid & ~inst_cancel;
    data_rvalid = in_data & (owner == OWNER_DATA) & r_valid;
    inst_rlast  = inst_rvalid & r_last;
    data_rlast  = data_rvalid & r_last;
    rdata       = in_data ? r_data : '0;
  end

endmodule
